// File: rtl/sent_tx_crc_sched.sv
// sent_tx_crc_sched: time-shares the SENT TX combinational CRC generator
// between the fast-channel, short-serial and enhanced-serial builders.
// One job at a time: grant, hold generator inputs for the settle window,
// capture the CRC, pulse done, return to idle.
module sent_tx_crc_sched #(
  parameter int SETTLE_CYCLES = 2,
  parameter bit FC_PRIORITY   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fc_req,
  input  logic [1:0]  fc_len,
  input  logic [23:0] fc_data,
  output logic        fc_gnt,
  output logic        fc_done,
  input  logic        sm_req,
  input  logic [11:0] sm_data,
  output logic        sm_gnt,
  output logic        sm_done,
  input  logic        em_req,
  input  logic [23:0] em_data,
  output logic        em_gnt,
  output logic        em_done,
  output logic [5:0]  rsp_crc,
  output logic        busy,
  output logic [2:0]  crc_enable,
  output logic [23:0] crc_data,
  input  logic [3:0]  crc_fast_in,
  input  logic [3:0]  crc_serial_in,
  input  logic [5:0]  crc_enhanced_in
);

  // A zero settle window still needs one full cycle through the generator.
  localparam int            S        = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int            CW       = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(S - 1);

  typedef enum logic [1:0] {ID_FC = 2'd0, ID_SM = 2'd1, ID_EM = 2'd2} req_id_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  req_id_t       ptr_q, ptr_d;
  req_id_t       win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    done_q, done_d;
  logic [2:0]    en_q, en_d;
  logic [23:0]   data_q, data_d;
  logic [5:0]    rsp_q, rsp_d;

  logic [2:0]    rr_req;
  logic          any_req;
  logic [1:0]    idx;
  req_id_t       win_id;

  // Fast-channel enable code from the nibble count; reserved length behaves as 6 nibbles.
  function automatic logic [2:0] fc_code(input logic [1:0] len);
    case (len)
      2'd0:    return 3'b011;
      2'd1:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Winner: optional FC override, else rotate starting after the last winner.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    rr_req  = {em_req, sm_req, fc_req & ~FC_PRIORITY};
    any_req = fc_req | sm_req | em_req;
    win_id  = ptr_q;
    idx     = '0;
    // Walk from farthest to nearest so the nearest requester is assigned last and wins.
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(ptr_q) + k) % 3);
      if (rr_req[idx]) win_id = req_id_t'(idx);
    end
    if (FC_PRIORITY && fc_req) win_id = ID_FC;
  end

  // State register.
  // NOTE: sequential blocks use <= only; combinational next-state logic uses =.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: start on any request, leave RUN when the settle count expires.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: grant and load in IDLE, capture in RUN, release in DONE.
  always_comb begin
    ptr_d  = ptr_q;
    win_d  = win_q;
    cnt_d  = cnt_q;
    gnt_d  = 3'b000;
    done_d = 3'b000;
    en_d   = en_q;
    data_d = data_q;
    rsp_d  = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d = win_id;
          ptr_d = win_id;
          cnt_d = CNT_LOAD;
          gnt_d = 3'b001 << win_id;
          case (win_id)
            ID_FC: begin
              en_d   = fc_code(fc_len);
              data_d = fc_data;
            end
            ID_SM: begin
              en_d   = 3'b100;
              data_d = {12'b0, sm_data};
            end
            default: begin
              en_d   = 3'b101;
              data_d = em_data;
            end
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          done_d = 3'b001 << win_q;
          case (win_q)
            ID_FC:   rsp_d = {2'b00, crc_fast_in};
            ID_SM:   rsp_d = {2'b00, crc_serial_in};
            default: rsp_d = crc_enhanced_in;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    en_d = 3'b000;
      default: ;
    endcase
  end

  // Datapath registers; reset drops any job in flight and parks the pointer on EM.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= ID_EM;
      win_q  <= ID_FC;
      cnt_q  <= '0;
      gnt_q  <= 3'b000;
      done_q <= 3'b000;
      en_q   <= 3'b000;
      data_q <= '0;
      rsp_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      en_q   <= en_d;
      data_q <= data_d;
      rsp_q  <= rsp_d;
    end
  end

  assign fc_gnt     = gnt_q[0];
  assign sm_gnt     = gnt_q[1];
  assign em_gnt     = gnt_q[2];
  assign fc_done    = done_q[0];
  assign sm_done    = done_q[1];
  assign em_done    = done_q[2];
  assign rsp_crc    = rsp_q;
  assign busy       = (state_q != IDLE);
  assign crc_enable = en_q;
  assign crc_data   = data_q;

endmodule

// File: tb/tb_sent_tx_crc_sched.sv
// Bench for sent_tx_crc_sched: two instances (round-robin and FC-priority),
// a stand-in CRC generator that outputs garbage in the first cycle after its
// inputs change, and a job-level model compared against every output each cycle.
module tb_sent_tx_crc_sched;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        fc_req [2];
  logic [1:0]  fc_len [2];
  logic [23:0] fc_data [2];
  logic        sm_req [2];
  logic [11:0] sm_data [2];
  logic        em_req [2];
  logic [23:0] em_data [2];
  logic        fc_gnt [2], fc_done [2], sm_gnt [2], sm_done [2], em_gnt [2], em_done [2];
  logic        busy [2];
  logic [5:0]  rsp_crc [2];
  logic [2:0]  crc_enable [2];
  logic [23:0] crc_data [2];
  logic [3:0]  crc_fast_in [2];
  logic [3:0]  crc_serial_in [2];
  logic [5:0]  crc_enhanced_in [2];

  sent_tx_crc_sched #(.SETTLE_CYCLES(S), .FC_PRIORITY(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .fc_req(fc_req[0]), .fc_len(fc_len[0]), .fc_data(fc_data[0]), .fc_gnt(fc_gnt[0]), .fc_done(fc_done[0]),
    .sm_req(sm_req[0]), .sm_data(sm_data[0]), .sm_gnt(sm_gnt[0]), .sm_done(sm_done[0]),
    .em_req(em_req[0]), .em_data(em_data[0]), .em_gnt(em_gnt[0]), .em_done(em_done[0]),
    .rsp_crc(rsp_crc[0]), .busy(busy[0]), .crc_enable(crc_enable[0]), .crc_data(crc_data[0]),
    .crc_fast_in(crc_fast_in[0]), .crc_serial_in(crc_serial_in[0]), .crc_enhanced_in(crc_enhanced_in[0])
  );

  sent_tx_crc_sched #(.SETTLE_CYCLES(S), .FC_PRIORITY(1'b1)) u_pri (
    .clk(clk), .reset(reset),
    .fc_req(fc_req[1]), .fc_len(fc_len[1]), .fc_data(fc_data[1]), .fc_gnt(fc_gnt[1]), .fc_done(fc_done[1]),
    .sm_req(sm_req[1]), .sm_data(sm_data[1]), .sm_gnt(sm_gnt[1]), .sm_done(sm_done[1]),
    .em_req(em_req[1]), .em_data(em_data[1]), .em_gnt(em_gnt[1]), .em_done(em_done[1]),
    .rsp_crc(rsp_crc[1]), .busy(busy[1]), .crc_enable(crc_enable[1]), .crc_data(crc_data[1]),
    .crc_fast_in(crc_fast_in[1]), .crc_serial_in(crc_serial_in[1]), .crc_enhanced_in(crc_enhanced_in[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // SENT CRC-4 (seed 5, x^4+x^3+x^2+1) over n nibbles, MSB nibble first, plus one zero nibble.
  function automatic logic [3:0] crc4(input logic [23:0] d, input int n);
    logic [3:0] c;
    logic [3:0] nib;
    logic       fb;
    c = 4'h5;
    for (int i = n; i >= 0; i--) begin
      nib = 4'h0;
      if (i > 0) nib = d[4*(i-1) +: 4];
      for (int b = 3; b >= 0; b--) begin
        fb = c[3] ^ nib[b];
        c  = {c[2:0], 1'b0};
        if (fb) c = c ^ 4'hD;
      end
    end
    return c;
  endfunction

  // CRC-6 (seed 0x15, x^6+x^4+x^3+1) over 24 data bits plus six zero bits.
  function automatic logic [5:0] crc6(input logic [23:0] d);
    logic [5:0]  c;
    logic [29:0] bits;
    logic        fb;
    c    = 6'h15;
    bits = {d, 6'b0};
    for (int b = 29; b >= 0; b--) begin
      fb = c[5] ^ bits[b];
      c  = {c[4:0], 1'b0};
      if (fb) c = c ^ 6'h19;
    end
    return c;
  endfunction

  function automatic int fc_nibbles(input logic [1:0] len);
    if (len == 2'd0) return 3;
    if (len == 2'd1) return 4;
    return 6;
  endfunction

  // Stand-in generator: correct outputs only once its inputs have been stable for a full cycle.
  logic [2:0]  g_prev_en [2];
  logic [23:0] g_prev_data [2];

  task automatic gen_update(input int d);
    logic [3:0] f, s;
    logic [5:0] e;
    int         n;
    n = (crc_enable[d] == 3'b011) ? 3 : (crc_enable[d] == 3'b010) ? 4 : 6;
    f = crc4(crc_data[d], n);
    s = crc4(crc_data[d], 3);
    e = crc6(crc_data[d]);
    if ((crc_enable[d] !== g_prev_en[d]) || (crc_data[d] !== g_prev_data[d])) begin
      f = f ^ 4'(1 + $urandom_range(14));
      s = s ^ 4'(1 + $urandom_range(14));
      e = e ^ 6'(1 + $urandom_range(62));
    end
    crc_fast_in[d]     = f;
    crc_serial_in[d]   = s;
    crc_enhanced_in[d] = e;
    g_prev_en[d]       = crc_enable[d];
    g_prev_data[d]     = crc_data[d];
  endtask

  // Job-level model: m_k is the position inside the current job (0 = idle, 1 = grant cycle).
  int          m_k [2];
  int          m_win [2];
  int          m_ptr [2];
  logic [2:0]  m_en [2];
  logic [23:0] m_data [2];
  logic [5:0]  m_crc [2];
  logic [5:0]  m_rsp [2];

  function automatic int pick(input int ptr, input logic f, input logic s, input logic e, input bit prio);
    logic [2:0] r;
    int         id;
    if (prio && f) return 0;
    r = {e, s, f & ~prio};
    for (int i = 1; i <= 3; i++) begin
      id = (ptr + i) % 3;
      if (r[id[1:0]]) return id;
    end
    return -1;
  endfunction

  task automatic m_step(input int d);
    int w;
    if (reset) begin
      m_k[d] = 0; m_ptr[d] = 2; m_en[d] = 3'b000; m_data[d] = '0; m_rsp[d] = '0;
    end else if (m_k[d] == 0) begin
      w = pick(m_ptr[d], fc_req[d], sm_req[d], em_req[d], d == 1);
      if (w >= 0) begin
        m_win[d] = w; m_ptr[d] = w; m_k[d] = 1;
        if (w == 0) begin
          m_en[d]   = (fc_len[d] == 2'd0) ? 3'b011 : (fc_len[d] == 2'd1) ? 3'b010 : 3'b001;
          m_data[d] = fc_data[d];
          m_crc[d]  = {2'b00, crc4(fc_data[d], fc_nibbles(fc_len[d]))};
        end else if (w == 1) begin
          m_en[d]   = 3'b100;
          m_data[d] = {12'b0, sm_data[d]};
          m_crc[d]  = {2'b00, crc4({12'b0, sm_data[d]}, 3)};
        end else begin
          m_en[d]   = 3'b101;
          m_data[d] = em_data[d];
          m_crc[d]  = crc6(em_data[d]);
        end
      end
    end else if (m_k[d] == S + 1) begin
      m_k[d] = 0;
    end else begin
      m_k[d]++;
      if (m_k[d] == S + 1) m_rsp[d] = m_crc[d];
    end
  endtask

  task automatic m_compare(input int d);
    logic [2:0] oh, eg, ed;
    oh = 3'b001 << m_win[d];
    eg = (m_k[d] == 1) ? oh : 3'b000;
    ed = (m_k[d] == S + 1) ? oh : 3'b000;
    check($sformatf("dut%0d gnt", d),  32'({em_gnt[d], sm_gnt[d], fc_gnt[d]}), 32'(eg));
    check($sformatf("dut%0d done", d), 32'({em_done[d], sm_done[d], fc_done[d]}), 32'(ed));
    check($sformatf("dut%0d busy", d), 32'(busy[d]), 32'(m_k[d] != 0));
    check($sformatf("dut%0d crc_enable", d), 32'(crc_enable[d]), 32'((m_k[d] != 0) ? m_en[d] : 3'b000));
    check($sformatf("dut%0d crc_data", d), 32'(crc_data[d]), 32'(m_data[d]));
    check($sformatf("dut%0d rsp_crc", d),  32'(rsp_crc[d]), 32'(m_rsp[d]));
  endtask

  bit rand_on = 1'b0;

  // Random requesters honour the contract: data stable until grant, request dropped on grant.
  task automatic rand_requesters(input int d);
    if (fc_req[d] && fc_gnt[d]) fc_req[d] = 1'b0;
    else if (!fc_req[d] && $urandom_range(3) == 0) begin
      fc_req[d] = 1'b1; fc_len[d] = 2'($urandom_range(3)); fc_data[d] = 24'($urandom);
    end
    if (sm_req[d] && sm_gnt[d]) sm_req[d] = 1'b0;
    else if (!sm_req[d] && $urandom_range(3) == 0) begin
      sm_req[d] = 1'b1; sm_data[d] = 12'($urandom);
    end
    if (em_req[d] && em_gnt[d]) em_req[d] = 1'b0;
    else if (!em_req[d] && $urandom_range(3) == 0) begin
      em_req[d] = 1'b1; em_data[d] = 24'($urandom);
    end
  endtask

  // One clock: sample after the edge, advance model, compare, refresh generator, drive requesters.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_step(d);
      m_compare(d);
      gen_update(d);
      if (rand_on) rand_requesters(d);
    end
  endtask

  function automatic logic gnt_of(input int d, input int r);
    return (r == 0) ? fc_gnt[d] : (r == 1) ? sm_gnt[d] : em_gnt[d];
  endfunction

  function automatic logic done_of(input int d, input int r);
    return (r == 0) ? fc_done[d] : (r == 1) ? sm_done[d] : em_done[d];
  endfunction

  // Single job on the round-robin instance; reports what was seen at grant and done.
  task automatic run_job(input int r, input logic [1:0] len, input logic [23:0] data,
                         output logic [2:0] en_g, output logic [23:0] data_g,
                         output logic [5:0] rsp, output int gnt_t, output int done_t);
    if (r == 0) begin fc_req[0] = 1'b1; fc_len[0] = len; fc_data[0] = data; end
    else if (r == 1) begin sm_req[0] = 1'b1; sm_data[0] = data[11:0]; end
    else begin em_req[0] = 1'b1; em_data[0] = data; end
    gnt_t = -1; done_t = -1; en_g = '0; data_g = '0; rsp = '0;
    for (int t = 1; t <= 12 && done_t < 0; t++) begin
      tick();
      if (gnt_of(0, r)) begin
        gnt_t = t; en_g = crc_enable[0]; data_g = crc_data[0];
        if (r == 0) fc_req[0] = 1'b0; else if (r == 1) sm_req[0] = 1'b0; else em_req[0] = 1'b0;
      end
      if (done_of(0, r)) begin done_t = t; rsp = rsp_crc[0]; end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  en_g;
    logic [23:0] data_g;
    logic [5:0]  rsp;
    int          gt, dt, cnt_fc, cnt_sm, last_fc, wait_t, ndone;
    int          g_id [4];
    int          g_t  [4];
    int          d_t0;
    int          ng;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fc_req[d] = 1'b0; fc_len[d] = 2'd0; fc_data[d] = '0;
      sm_req[d] = 1'b0; sm_data[d] = '0;
      em_req[d] = 1'b0; em_data[d] = '0;
      crc_fast_in[d] = '0; crc_serial_in[d] = '0; crc_enhanced_in[d] = '0;
      m_k[d] = 0; m_win[d] = 0; m_ptr[d] = 2; m_en[d] = '0; m_data[d] = '0; m_crc[d] = '0; m_rsp[d] = '0;
    end
    tick();
    tick();
    check("reset busy", 32'(busy[0]), 32'd0);
    check("reset crc_enable", 32'(crc_enable[0]), 32'd0);
    check("reset rsp_crc", 32'(rsp_crc[0]), 32'd0);
    check("reset gnt/done", 32'({fc_gnt[0], sm_gnt[0], em_gnt[0], fc_done[0], sm_done[0], em_done[0]}), 32'd0);
    reset = 1'b0;
    tick();

    // Fast channel, three zero nibbles.
    run_job(0, 2'd0, 24'h0, en_g, data_g, rsp, gt, dt);
    check("fc len0 gnt cycle", 32'(gt), 32'd1);
    check("fc len0 enable", 32'(en_g), 32'b011);
    check("fc len0 done cycle", 32'(dt), 32'(S + 1));
    check("fc len0 rsp", 32'(rsp), 32'h09);

    run_job(0, 2'd1, 24'h0, en_g, data_g, rsp, gt, dt);
    check("fc len1 enable", 32'(en_g), 32'b010);
    check("fc len1 rsp", 32'(rsp), 32'h0C);

    run_job(0, 2'd2, 24'h0, en_g, data_g, rsp, gt, dt);
    check("fc len2 enable", 32'(en_g), 32'b001);

    run_job(0, 2'd3, 24'h0, en_g, data_g, rsp, gt, dt);
    check("fc len3 enable", 32'(en_g), 32'b001);

    run_job(1, 2'd0, 24'h0, en_g, data_g, rsp, gt, dt);
    check("sm enable", 32'(en_g), 32'b100);
    check("sm data", 32'(data_g), 32'd0);
    check("sm done cycle", 32'(dt), 32'(S + 1));
    check("sm rsp", 32'(rsp), 32'h09);

    run_job(2, 2'd0, 24'hABCDEF, en_g, data_g, rsp, gt, dt);
    check("em enable", 32'(en_g), 32'b101);
    check("em data", 32'(data_g), 32'hABCDEF);
    check("em done cycle", 32'(dt), 32'(S + 1));

    // Round robin from reset with all three requesters held high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fc_req[0] = 1'b1; fc_len[0] = 2'($urandom_range(3)); fc_data[0] = 24'($urandom);
    sm_req[0] = 1'b1; sm_data[0] = 12'($urandom);
    em_req[0] = 1'b1; em_data[0] = 24'($urandom);
    for (int i = 0; i < 4; i++) begin g_id[i] = -1; g_t[i] = -1; end
    ng = 0; d_t0 = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (ng < 4) begin
        if (fc_gnt[0]) begin g_id[ng] = 0; g_t[ng] = t; ng++; end
        else if (sm_gnt[0]) begin g_id[ng] = 1; g_t[ng] = t; ng++; end
        else if (em_gnt[0]) begin g_id[ng] = 2; g_t[ng] = t; ng++; end
        if (ng == 4) begin fc_req[0] = 1'b0; sm_req[0] = 1'b0; em_req[0] = 1'b0; end
      end
      if (d_t0 < 0 && fc_done[0]) d_t0 = t;
    end
    check("rr order 0", 32'(g_id[0]), 32'd0);
    check("rr order 1", 32'(g_id[1]), 32'd1);
    check("rr order 2", 32'(g_id[2]), 32'd2);
    check("rr order 3", 32'(g_id[3]), 32'd0);
    for (int i = 0; i < 3; i++) check($sformatf("rr gap %0d", i), 32'(g_t[i+1] - g_t[i]), 32'(S + 2));
    check("rr done after gnt", 32'(d_t0 - g_t[0]), 32'(S));

    // FC priority instance: FC and SM held high, SM must starve.
    fc_req[1] = 1'b1; fc_len[1] = 2'd1; fc_data[1] = 24'($urandom);
    sm_req[1] = 1'b1; sm_data[1] = 12'($urandom);
    cnt_fc = 0; cnt_sm = 0; last_fc = -100;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (fc_gnt[1]) begin
        if (cnt_fc > 0) check("pri fc gap", 32'(t - last_fc), 32'(S + 2));
        cnt_fc++; last_fc = t;
      end
      if (sm_gnt[1]) cnt_sm++;
    end
    check("pri fc grants", 32'(cnt_fc), 32'd6);
    check("pri sm grants", 32'(cnt_sm), 32'd0);
    fc_req[1] = 1'b0;
    wait_t = -1;
    for (int t = 1; t <= 8 && wait_t < 0; t++) begin
      tick();
      if (sm_gnt[1]) begin wait_t = t; sm_req[1] = 1'b0; end
    end
    check("pri sm after fc drop", 32'(wait_t), 32'd1);
    for (int t = 0; t < 4; t++) tick();

    // Reset in the first RUN cycle drops the job.
    em_req[0] = 1'b1; em_data[0] = 24'($urandom);
    tick();
    check("abort em gnt", 32'(em_gnt[0]), 32'd1);
    em_req[0] = 1'b0;
    reset = 1'b1;
    tick();
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort crc_enable", 32'(crc_enable[0]), 32'd0);
    check("abort rsp_crc", 32'(rsp_crc[0]), 32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (em_done[0]) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);

    // Randomized traffic on both instances, with occasional resets.
    rand_on = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0;
    rand_on = 1'b0;
    for (int d = 0; d < 2; d++) begin fc_req[d] = 1'b0; sm_req[d] = 1'b0; em_req[d] = 1'b0; end
    for (int t = 0; t < 8; t++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
